keypad_encoder: RTL and testbench
=================================

Name: keypad_encoder

Overview:
- Scans a 4x4 matrix keypad (Pmod KYPD layout), debounces it and encodes the pressed key into a 4-bit hex code with a one-cycle valid strobe.
- Input-side counterpart of the hex-to-seven-segment decoder: its key_code output feeds the decoder's 4-bit input on the board top level.
- Converts physical key position to a binary code, the opposite direction to the decoder.

Parameters:
- SCAN_DIV, 1000, clock cycles each column is driven; minimum 4.
- DEBOUNCE_SCANS, 8, consecutive identical full scans required to accept a press or a release; minimum 2.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- col  output  4  column drive, active-low, exactly one bit low at any time
- row  input  4  row sense, active-low (externally pulled up), asynchronous
- key_code  output  4  hex code of the last accepted key
- key_valid  output  1  one-cycle strobe when a new press is accepted
- key_held  output  1  high from acceptance until the debounced release

Behaviour:
- Reset values: col=4'b1110, key_code=0, key_valid=0, key_held=0; all counters 0; FSM in IDLE.
- Reset is synchronous, active-high and has priority over all other logic.
- Reset mid-scan or mid-debounce discards the candidate key and produces no strobe.
- row passes through a 2-flop synchronizer before use.
- Column slot timing:
  - A divider counts 0..SCAN_DIV-1 per column.
  - col rotates 1110 -> 1101 -> 1011 -> 0111 -> 1110 on the cycle after the divider reaches SCAN_DIV-1.
  - Synchronized row is sampled on divider count SCAN_DIV-1 (settle margin).
- Scan result: after column 3 is sampled, one full-scan result {found, code} is formed.
- Priority: the first column in scan order wins; within a column the lowest row index wins.
- Keymap (row r, col c):
  - r0: 1 2 3 A
  - r1: 4 5 6 B
  - r2: 7 8 9 C
  - r3: 0 F E D
- Debounce FSM, evaluated once per full scan. cnt counts consecutive qualifying scans.
  - IDLE: found -> PRESS_PEND, cand=code, cnt=1.
  - PRESS_PEND:
    - found and code==cand -> cnt+1.
    - When cnt reaches DEBOUNCE_SCANS -> HELD, key_code=cand, key_valid=1 for one cycle, key_held=1.
    - found with a different code -> restart with cand=code, cnt=1.
    - not found -> IDLE.
  - HELD:
    - not found -> REL_PEND, cnt=1.
    - found (any code) -> stay. No rollover and no second strobe while held.
  - REL_PEND:
    - not found -> cnt+1; at DEBOUNCE_SCANS -> IDLE, key_held=0.
    - found (any code) -> HELD, cnt=0, no new strobe.
- Latency: key_valid asserts on the cycle after the DEBOUNCE_SCANS-th matching scan completes.
- key_code holds its value through release until the next accepted press.
- Clean single press produces exactly one key_valid.
- Counters saturate. The divider wraps 0..SCAN_DIV-1 and the column index wraps 3 -> 0.

Optional Feature:
- Macro: KEYPAD_HISTORY_EN.
- Defined:
  - Extra output history[15:0], reset value 0.
  - On each key_valid: history <= {history[11:0], key_code}, updated on the same cycle key_code is updated.
  - Intended to drive four seven-segment digits.
- Undefined: port and register absent; behaviour otherwise identical.

Decomposition:
- Package keypad_pkg:
  - FSM state enum (IDLE, PRESS_PEND, HELD, REL_PEND).
  - NUM_ROWS=4, NUM_COLS=4.
  - KEYMAP constant (16 x 4-bit).
  - Column-drive reset constant 4'b1110.
- Sub-module sync_2ff (parameterised width), used for row.
- Divider, column rotation and FSM stay in keypad_encoder.

Test Plan (SCAN_DIV=4, DEBOUNCE_SCANS=3, full scan = 16 cycles):
- Reset, no keys, run 100 cycles -> col cycles 1110, 1101, 1011, 0111 every 4 cycles; key_valid never 1; key_held=0.
- Hold key 5 (row1 low only while col1 driven) steady -> exactly one key_valid within 64 cycles; key_code=4'h5; key_held=1; release -> key_held=0 within 64 cycles of release.
- Bounce key 9 (pressed 1 scan, released 1 scan, repeated 5 times) then hold -> no strobe during bounce; one strobe with key_code=4'h9 after the stable hold.
- Hold D, then also press 3 while D is held -> single strobe with code D; no strobe for 3. Press 1 and A in the same scan from idle -> code 1 (column 0 first).
- Assert rst mid-PRESS_PEND for key 0 -> no strobe; col=1110 and all outputs 0 on the next cycle; continued hold then yields one strobe with code 0.
- With KEYPAD_HISTORY_EN, press keys 1, 2, 3, 4 in sequence -> history=16'h1234.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad encoder: debounce states,
// matrix geometry, the key map and the column-drive reset pattern.
package keypad_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PRESS_PEND,
        HELD,
        REL_PEND
    } kp_state_t;

    localparam int NUM_ROWS = 4;
    localparam int NUM_COLS = 4;

    localparam logic [NUM_COLS-1:0] COL_RESET = 4'b1110;

    // Indexed by {row, col}; entry 0 is row 0 / column 0.
    localparam logic [NUM_ROWS*NUM_COLS-1:0][3:0] KEYMAP = {
        4'hD, 4'hE, 4'hF, 4'h0,
        4'hC, 4'h9, 4'h8, 4'h7,
        4'hB, 4'h6, 4'h5, 4'h4,
        4'hA, 4'h3, 4'h2, 4'h1
    };

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous level inputs; resets to RESET_VAL
// so the idle state of the input is seen straight out of reset.
module sync_2ff #(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/keypad_encoder.sv
// 4x4 matrix keypad scanner, debouncer and hex encoder.
// Optional KEYPAD_HISTORY_EN adds a 16-bit shift history of accepted keys.
module keypad_encoder
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV       = 1000,
    parameter int DEBOUNCE_SCANS = 8
) (
    input  logic        clk,
    input  logic        rst,
    output logic [3:0]  col,
    input  logic [3:0]  row,
    output logic [3:0]  key_code,
    output logic        key_valid,
    output logic        key_held
`ifdef KEYPAD_HISTORY_EN
    ,
    output logic [15:0] history
`endif
);

    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);
    localparam int CIX_W = $clog2(NUM_COLS);

    logic [DIV_W-1:0] div_cnt;
    logic [CIX_W-1:0] col_idx;
    logic             slot_end;
    logic             scan_done;
    logic [3:0]       row_s;

    sync_2ff #(.WIDTH(NUM_ROWS), .RESET_VAL('1)) u_row_sync (
        .clk (clk),
        .rst (rst),
        .d   (row),
        .q   (row_s)
    );

    assign slot_end  = (div_cnt == DIV_W'(SCAN_DIV - 1));
    assign scan_done = slot_end && (col_idx == CIX_W'(NUM_COLS - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt <= '0;
            col_idx <= '0;
            col     <= COL_RESET;
        end else if (slot_end) begin
            div_cnt <= '0;
            col_idx <= col_idx + 1'b1;
            col     <= {col[NUM_COLS-2:0], col[NUM_COLS-1]};
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    // Lowest active row in the driven column wins.
    logic       hit;
    logic [3:0] hit_code;

    always_comb begin
        hit      = 1'b0;
        hit_code = '0;
        for (int r = NUM_ROWS - 1; r >= 0; r--) begin
            if (!row_s[r]) begin
                hit      = 1'b1;
                hit_code = KEYMAP[{2'(r), col_idx}];
            end
        end
    end

    // Earliest column of the scan keeps the result; later hits are ignored.
    logic       found_acc;
    logic [3:0] code_acc;
    logic       scan_found;
    logic [3:0] scan_code;

    assign scan_found = found_acc | hit;
    assign scan_code  = found_acc ? code_acc : hit_code;

    always_ff @(posedge clk) begin
        if (rst) begin
            found_acc <= 1'b0;
            code_acc  <= '0;
        end else if (slot_end) begin
            if (scan_done) begin
                found_acc <= 1'b0;
                code_acc  <= '0;
            end else if (!found_acc && hit) begin
                found_acc <= 1'b1;
                code_acc  <= hit_code;
            end
        end
    end

    // key_valid: single-cycle strobe with no back-pressure; key_code is
    // stable while key_valid is high and stays until the next strobe.
    kp_state_t        state, state_n;
    logic [3:0]       cand, cand_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [3:0]       code_n;
    logic             valid_n;

    always_comb begin
        state_n = state;
        cand_n  = cand;
        cnt_n   = cnt;
        code_n  = key_code;
        valid_n = 1'b0;
        if (scan_done) begin
            case (state)
                IDLE: begin
                    if (scan_found) begin
                        state_n = PRESS_PEND;
                        cand_n  = scan_code;
                        cnt_n   = CNT_W'(1);
                    end
                end
                PRESS_PEND: begin
                    if (!scan_found) begin
                        state_n = IDLE;
                        cnt_n   = '0;
                    end else if (scan_code != cand) begin
                        cand_n = scan_code;
                        cnt_n  = CNT_W'(1);
                    end else if (cnt >= CNT_W'(DEBOUNCE_SCANS - 1)) begin
                        state_n = HELD;
                        code_n  = cand;
                        valid_n = 1'b1;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
                HELD: begin
                    if (!scan_found) begin
                        state_n = REL_PEND;
                        cnt_n   = CNT_W'(1);
                    end
                end
                REL_PEND: begin
                    if (scan_found) begin
                        state_n = HELD;
                        cnt_n   = '0;
                    end else if (cnt >= CNT_W'(DEBOUNCE_SCANS - 1)) begin
                        state_n = IDLE;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
                default: begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cand      <= '0;
            cnt       <= '0;
            key_code  <= '0;
            key_valid <= 1'b0;
        end else begin
            state     <= state_n;
            cand      <= cand_n;
            cnt       <= cnt_n;
            key_code  <= code_n;
            key_valid <= valid_n;
        end
    end

    assign key_held = (state == HELD) || (state == REL_PEND);

`ifdef KEYPAD_HISTORY_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            history <= '0;
        end else if (valid_n) begin
            history <= {history[11:0], cand};
        end
    end
`endif

endmodule

// File: tb/tb_keypad_encoder.sv
// Directed bench for keypad_encoder with a matrix model driving row from col;
// strobes are checked by a monitor against an expected-code queue.
module tb_keypad_encoder;

    logic        clk;
    logic        rst;
    logic [3:0]  col;
    logic [3:0]  row;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_held;
`ifdef KEYPAD_HISTORY_EN
    logic [15:0] history;
`endif

    logic [15:0] pressed;
    logic [3:0]  exp_q[$];
    int          total;
    int          bad;
    int          n_strobes;

    keypad_encoder #(.SCAN_DIV(4), .DEBOUNCE_SCANS(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .col       (col),
        .row       (row),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_held  (key_held)
`ifdef KEYPAD_HISTORY_EN
        ,
        .history   (history)
`endif
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // keypad matrix: pressed[{r,c}] pulls row r low while column c is driven low
    always_comb begin
        row = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (!col[c] && pressed[{2'(r), 2'(c)}]) row[r] = 1'b0;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        if (key_valid) begin
            n_strobes++;
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_strobe: got key_code=%h want no strobe", key_code);
            end else begin
                logic [3:0] e;
                e = exp_q.pop_front();
                if (key_code !== e) begin
                    bad++;
                    $display("FAIL strobe_code: got %h want %h", key_code, e);
                end
            end
        end
    end

    // driver tasks
    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic wait_strobe(input string name, input int budget);
        int start;
        bit seen;
        start = n_strobes;
        seen  = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            #1;
            if (n_strobes > start) seen = 1'b1;
        end
        check(name, 32'(seen), 32'd1);
    endtask

    task automatic wait_release(input string name, input int budget);
        bit done;
        done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            @(negedge clk);
            #1;
            if (!key_held) done = 1'b1;
        end
        check(name, 32'(done), 32'd1);
    endtask

    task automatic press_accept(input int idx, input logic [3:0] code, input string name);
        exp_q.push_back(code);
        pressed[idx] = 1'b1;
        wait_strobe({name, "_strobe"}, 64);
        check({name, "_code"}, 32'(key_code), 32'(code));
        check({name, "_held"}, 32'(key_held), 32'd1);
    endtask

    task automatic release_all(input string name);
        pressed = '0;
        wait_release({name, "_release"}, 64);
    endtask

    initial begin
        logic [3:0] ecol;
        total     = 0;
        bad       = 0;
        n_strobes = 0;
        pressed   = '0;
        rst       = 1'b1;

        // reset state and idle column rotation
        cycles(3);
        check("rst_col", 32'(col), 32'hE);
        check("rst_code", 32'(key_code), 32'h0);
        check("rst_valid", 32'(key_valid), 32'h0);
        check("rst_held", 32'(key_held), 32'h0);
`ifdef KEYPAD_HISTORY_EN
        check("rst_history", 32'(history), 32'h0);
`endif
        rst = 1'b0;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            #1;
            ecol = 4'hF ^ (4'h1 << ((k / 4) % 4));
            check("idle_col", 32'(col), 32'(ecol));
        end
        check("idle_held", 32'(key_held), 32'h0);

        // key 5 steady hold and release; code persists after release
        press_accept(5, 4'h5, "key5");
        cycles(48);
        check("key5_still_held", 32'(key_held), 32'd1);
        release_all("key5");
        check("key5_code_kept", 32'(key_code), 32'h5);

        // key 9 bouncing one scan on / one scan off, then stable
        for (int i = 0; i < 5; i++) begin
            pressed[10] = 1'b1;
            cycles(16);
            pressed[10] = 1'b0;
            cycles(16);
        end
        check("bounce_no_held", 32'(key_held), 32'h0);
        press_accept(10, 4'h9, "key9");
        release_all("key9");

        // D held, 3 added during hold -> no second strobe
        press_accept(15, 4'hD, "keyD");
        pressed[2] = 1'b1;
        cycles(64);
        check("keyD_3_code", 32'(key_code), 32'hD);
        check("keyD_3_held", 32'(key_held), 32'd1);
        release_all("keyD");

        // 1 and A together from idle -> column 0 wins
        pressed[3] = 1'b1;
        press_accept(0, 4'h1, "key1A");
        release_all("key1A");

        // reset during press debounce of key 0
        pressed[12] = 1'b1;
        cycles(32);
        check("k0_pend_held", 32'(key_held), 32'h0);
        rst = 1'b1;
        cycles(1);
        check("k0_rst_col", 32'(col), 32'hE);
        check("k0_rst_code", 32'(key_code), 32'h0);
        check("k0_rst_valid", 32'(key_valid), 32'h0);
        check("k0_rst_held", 32'(key_held), 32'h0);
        rst = 1'b0;
        exp_q.push_back(4'h0);
        wait_strobe("key0_strobe", 64);
        check("key0_code", 32'(key_code), 32'h0);
        check("key0_held", 32'(key_held), 32'd1);
        release_all("key0");

        // sequence 1, 2, 3, 4
        press_accept(0, 4'h1, "seq1");
        release_all("seq1");
        press_accept(1, 4'h2, "seq2");
        release_all("seq2");
        press_accept(2, 4'h3, "seq3");
        release_all("seq3");
        press_accept(4, 4'h4, "seq4");
        release_all("seq4");
`ifdef KEYPAD_HISTORY_EN
        check("history", 32'(history), 32'h1234);
`endif

        cycles(32);
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        check("strobe_count", 32'(n_strobes), 32'd9);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
